// File: rtl/datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
// Shared writeback-stage types and constants.
//   WB_SRC_*   : scalar completion source ids (wb_fu encoding)
//   wb_src_t   : one buffered completion {wen, rd, wdata}
//   wb_t       : registered writeback record driven towards issue
// -----------------------------------------------------------------------------
package datapath_pkg;

    localparam int WB_NUM_SRC = 3;
    localparam int WB_REG_W   = 5;
    localparam int WB_WORD_W  = 32;
    localparam int WB_FU_W    = 2;

    localparam logic [WB_FU_W-1:0] WB_SRC_ALU  = 2'd0;
    localparam logic [WB_FU_W-1:0] WB_SRC_LDST = 2'd1;
    localparam logic [WB_FU_W-1:0] WB_SRC_BR   = 2'd2;

    typedef struct packed {
        logic                 wen;
        logic [WB_REG_W-1:0]  rd;
        logic [WB_WORD_W-1:0] wdata;
    } wb_src_t;

    typedef struct packed {
        logic                 valid;
        logic [WB_FU_W-1:0]   fu;     // one of WB_SRC_*
        logic                 reg_en;
        logic [WB_REG_W-1:0]  rd;
        logic [WB_WORD_W-1:0] wdata;
    } wb_t;

    // x0 is hardwired to zero, so a write to it is dropped while the
    // completion itself still retires.
    function automatic logic wb_writes_reg(wb_src_t s);
        return s.wen && (s.rd != '0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with an internal last-winner pointer.
//   CLK, nRST : clock, synchronous active-low reset
//   req       : request vector
//   en        : grant enable (no grant and no pointer move when low)
//   gnt       : one-hot grant
//   gnt_idx   : index of the granted requester
// The search starts one past the last winner; the pointer resets to N-1 so
// requester 0 has priority after reset.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N     = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int off = 1; off <= N; off++) begin
            cand = IDX_W'((int'(ptr_q) + off) % N);
            if (!found && en && req[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = cand;
            end
        end
        ptr_d = found ? gnt_idx : ptr_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge CLK) begin
        if (!nRST) ptr_q <= IDX_W'(N - 1);
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Scalar writeback stage: one completion buffer per source, one register-file
// write per cycle, round-robin across sources.
//   CLK, nRST  : clock, synchronous active-low reset
//   freeze     : hazard stall; blocks accepts and grants, state holds
//   src_valid  : per-source completion valid
//   src_ready  : per-source accept (transfer = valid & ready)
//   src_wen    : completion writes a register
//   src_rd     : destination register per source
//   src_wdata  : result per source
//   wb_valid   : one-cycle pulse per retired completion
//   wb_fu      : source id of the retired completion
//   wb_reg_en  : register-file write enable (0 for wen=0 or rd=x0)
//   wb_rd      : destination register
//   s_wdata    : write data
// -----------------------------------------------------------------------------
module wb_arbiter
    import datapath_pkg::*;
#(
    parameter int NUM_SRC = WB_NUM_SRC,
    parameter int REG_W   = WB_REG_W,
    parameter int WORD_W  = WB_WORD_W
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic                            freeze,
    input  logic [NUM_SRC-1:0]              src_valid,
    output logic [NUM_SRC-1:0]              src_ready,
    input  logic [NUM_SRC-1:0]              src_wen,
    input  logic [NUM_SRC-1:0][REG_W-1:0]   src_rd,
    input  logic [NUM_SRC-1:0][WORD_W-1:0]  src_wdata,
    output logic                            wb_valid,
    output logic [1:0]                      wb_fu,
    output logic                            wb_reg_en,
    output logic [REG_W-1:0]                wb_rd,
    output logic [WORD_W-1:0]               s_wdata
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    wb_src_t              buf_q [NUM_SRC];
    logic [NUM_SRC-1:0]   occ_q, occ_d;
    logic [NUM_SRC-1:0]   xfer;
    logic [NUM_SRC-1:0]   gnt;
    logic [IDX_W-1:0]     gnt_idx;
    wb_t                  wb_q, wb_d;
    wb_src_t              sel;

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .CLK     (CLK),
        .nRST    (nRST),
        .req     (occ_q),
        .en      (!freeze),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // A buffer being drained this cycle can take a new entry at the same edge.
    always_comb begin
        src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++)
            src_ready[i] = !freeze && (!occ_q[i] || gnt[i]);
    end

    assign xfer  = src_valid & src_ready;
    assign occ_d = (occ_q & ~gnt) | xfer;

    always_ff @(posedge CLK) begin
        if (!nRST) occ_q <= '0;
        else       occ_q <= occ_d;
    end

    // NOTE: the payload needs no reset; the occupancy bits alone decide
    // whether an entry is live, so stale data is never observed.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (xfer[i]) begin
                buf_q[i].wen   <= src_wen[i];
                buf_q[i].rd    <= src_rd[i];
                buf_q[i].wdata <= src_wdata[i];
            end
        end
    end

    // One-hot grant selects the winning entry.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (gnt[i]) sel = buf_q[i];
    end

    // Without a grant only the strobes drop; rd/wdata/fu hold.
    always_comb begin
        wb_d        = wb_q;
        wb_d.valid  = 1'b0;
        wb_d.reg_en = 1'b0;
        if (|gnt) begin
            wb_d.valid  = 1'b1;
            wb_d.fu     = WB_FU_W'(gnt_idx);
            wb_d.reg_en = wb_writes_reg(sel);
            wb_d.rd     = sel.rd;
            wb_d.wdata  = sel.wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) wb_q <= '0;
        else       wb_q <= wb_d;
    end

    assign wb_valid  = wb_q.valid;
    assign wb_fu     = wb_q.fu;
    assign wb_reg_en = wb_q.reg_en;
    assign wb_rd     = wb_q.rd;
    assign s_wdata   = wb_q.wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed stimulus pushes hand-computed writeback records (including the
// cycle each must appear in) into a scoreboard; a monitor on the falling edge
// pops and compares every wb_valid pulse.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              freeze = 1'b0;
    logic [2:0]        src_valid = '0;
    logic [2:0]        src_ready;
    logic [2:0]        src_wen = '0;
    logic [2:0][4:0]   src_rd = '0;
    logic [2:0][31:0]  src_wdata = '0;
    logic              wb_valid;
    logic [1:0]        wb_fu;
    logic              wb_reg_en;
    logic [4:0]        wb_rd;
    logic [31:0]       s_wdata;

    wb_arbiter dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .freeze    (freeze),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_wen   (src_wen),
        .src_rd    (src_rd),
        .src_wdata (src_wdata),
        .wb_valid  (wb_valid),
        .wb_fu     (wb_fu),
        .wb_reg_en (wb_reg_en),
        .wb_rd     (wb_rd),
        .s_wdata   (s_wdata)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  fu;
        logic [4:0]  rd;
        logic        reg_en;
        logic [31:0] wdata;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_wb(input logic [1:0] fu, input logic [4:0] rd, input logic en,
                             input logic [31:0] wdata, input int due);
        exp_t e;
        e.fu = fu; e.rd = rd; e.reg_en = en; e.wdata = wdata; e.due = due;
        sb.push_back(e);
    endtask

    // Monitor: every pulse must match the oldest expected record.
    always @(negedge CLK) begin
        if (wb_valid === 1'b1) begin
            check("wb_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("wb_fu",     64'(wb_fu),     64'(e.fu));
                check("wb_rd",     64'(wb_rd),     64'(e.rd));
                check("wb_reg_en", 64'(wb_reg_en), 64'(e.reg_en));
                check("s_wdata",   64'(s_wdata),   64'(e.wdata));
                check("wb_cycle",  64'(cyc),       64'(e.due));
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input int i, input logic wen, input logic [4:0] rd, input logic [31:0] d);
        src_valid[i] = 1'b1;
        src_wen[i]   = wen;
        src_rd[i]    = rd;
        src_wdata[i] = d;
    endtask

    // Bounded wait for the scoreboard to empty, then two idle cycles so the
    // monitor can catch any extra pulse.
    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        step();
        step();
        check({"drain_", name}, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        @(negedge CLK);
        check({name, "_wb_valid"},  64'(wb_valid),  64'd0);
        check({name, "_wb_fu"},     64'(wb_fu),     64'd0);
        check({name, "_wb_reg_en"}, 64'(wb_reg_en), 64'd0);
        check({name, "_wb_rd"},     64'(wb_rd),     64'd0);
        check({name, "_s_wdata"},   64'(s_wdata),   64'd0);
        check({name, "_src_ready"}, 64'(src_ready), 64'b111);
    endtask

    task automatic do_reset();
        src_valid = '0;
        freeze    = 1'b0;
        nRST      = 1'b0;
        step();
        nRST      = 1'b1;
        sb.delete();
    endtask

    initial begin
        int c0;

        // Reset state
        step();
        step();
        nRST = 1'b1;
        check_idle_outputs("reset");
        step();

        // 1: single ALU completion, 2-edge latency
        c0 = cyc;
        drive(0, 1'b1, 5'd5, 32'hDEADBEEF);
        expect_wb(2'd0, 5'd5, 1'b1, 32'hDEADBEEF, c0 + 2);
        @(negedge CLK);
        check("t1_src_ready0", 64'(src_ready[0]), 64'd1);
        step();
        src_valid = '0;
        drain("single");

        // 2: three simultaneous completions from reset
        do_reset();
        c0 = cyc;
        drive(0, 1'b1, 5'd1, 32'h0000_0101);
        drive(1, 1'b1, 5'd2, 32'h0000_0102);
        drive(2, 1'b1, 5'd3, 32'h0000_0103);
        expect_wb(2'd0, 5'd1, 1'b1, 32'h0000_0101, c0 + 2);
        expect_wb(2'd1, 5'd2, 1'b1, 32'h0000_0102, c0 + 3);
        expect_wb(2'd2, 5'd3, 1'b1, 32'h0000_0103, c0 + 4);
        step();
        src_valid = '0;
        drain("simultaneous");

        // 3: x0 destination and store (wen=0)
        c0 = cyc;
        drive(1, 1'b1, 5'd0, 32'h0000_0055);
        expect_wb(2'd1, 5'd0, 1'b0, 32'h0000_0055, c0 + 2);
        step();
        src_valid = '0;
        drain("x0");
        c0 = cyc;
        drive(1, 1'b0, 5'd7, 32'h0000_0077);
        expect_wb(2'd1, 5'd7, 1'b0, 32'h0000_0077, c0 + 2);
        step();
        src_valid = '0;
        drain("store");

        // 4: ALU and LDST streaming for 20 cycles -> 21 alternating pulses
        c0 = cyc;
        drive(0, 1'b1, 5'd10, 32'hAAAA_0000);
        drive(1, 1'b1, 5'd11, 32'hBBBB_0000);
        for (int t = 2; t <= 22; t++) begin
            if (t % 2 == 0) expect_wb(2'd0, 5'd10, 1'b1, 32'hAAAA_0000, c0 + t);
            else            expect_wb(2'd1, 5'd11, 1'b1, 32'hBBBB_0000, c0 + t);
        end
        repeat (20) step();
        src_valid = '0;
        drain("fairness");

        // 5: freeze with all buffers full; pointer last at ALU
        c0 = cyc;
        drive(0, 1'b1, 5'd21, 32'h0000_0021);
        drive(1, 1'b1, 5'd22, 32'h0000_0022);
        drive(2, 1'b1, 5'd23, 32'h0000_0023);
        expect_wb(2'd1, 5'd22, 1'b1, 32'h0000_0022, c0 + 5);
        expect_wb(2'd2, 5'd23, 1'b1, 32'h0000_0023, c0 + 6);
        expect_wb(2'd0, 5'd21, 1'b1, 32'h0000_0021, c0 + 7);
        step();
        freeze = 1'b1;
        drive(0, 1'b1, 5'd29, 32'h0000_0099);
        drive(1, 1'b1, 5'd29, 32'h0000_0099);
        drive(2, 1'b1, 5'd29, 32'h0000_0099);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("t5_src_ready", 64'(src_ready), 64'b000);
            check("t5_wb_valid",  64'(wb_valid),  64'd0);
            step();
        end
        freeze    = 1'b0;
        src_valid = '0;
        drain("freeze");

        // 6: reset while busy; pointer held at LDST by freeze before reset
        c0 = cyc;
        drive(0, 1'b1, 5'd1, 32'h0000_0601);
        drive(1, 1'b1, 5'd2, 32'h0000_0602);
        drive(2, 1'b1, 5'd3, 32'h0000_0603);
        expect_wb(2'd1, 5'd2, 1'b1, 32'h0000_0602, c0 + 2);
        step();
        src_valid = '0;
        step();
        freeze = 1'b1;
        nRST   = 1'b0;
        @(negedge CLK);
        check("t6_wb_valid_before", 64'(wb_valid), 64'd1);
        step();
        nRST   = 1'b1;
        freeze = 1'b0;
        check_idle_outputs("t6_after_reset");
        repeat (4) step();
        check("t6_no_stale", 64'(sb.size()), 64'd0);
        c0 = cyc;
        drive(0, 1'b1, 5'd9,  32'h0000_0909);
        drive(2, 1'b1, 5'd12, 32'h0000_0C0C);
        expect_wb(2'd0, 5'd9,  1'b1, 32'h0000_0909, c0 + 2);
        expect_wb(2'd2, 5'd12, 1'b1, 32'h0000_0C0C, c0 + 3);
        step();
        src_valid = '0;
        drain("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage for scalar completions. Sits between the scalar function units (ALU, load/store, branch link) and the issue stage.
- Buffers one completion per source and grants exactly one register-file write per cycle, round-robin.
- Drives the registered writeback record (valid, FU id, rd, reg enable) and the write data that issue uses to release FUST rows and wake waiting operands.

Parameters:
- NUM_SRC, 3, number of scalar completion sources (0=ALU, 1=LDST, 2=BRANCH).
- REG_W, 5, scalar register index width.
- WORD_W, 32, scalar data width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  synchronous active-low reset.
- freeze  in  1  pipeline stall from hazard unit.
- src_valid  in  NUM_SRC  per-source completion valid.
- src_ready  out  NUM_SRC  per-source accept; a transfer occurs when valid & ready.
- src_wen  in  NUM_SRC  completion writes a register (0 for store or branch without link).
- src_rd  in  NUM_SRC x REG_W  destination register per source.
- src_wdata  in  NUM_SRC x WORD_W  result per source.
- wb_valid  out  1  one-cycle pulse; one completion retired.
- wb_fu  out  2  index of retired source.
- wb_reg_en  out  1  register-file write enable.
- wb_rd  out  REG_W  destination register.
- s_wdata  out  WORD_W  write data.

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is synchronous and active-low; it is sampled only on the CLK rising edge.
- Reset values:
  - All outputs 0.
  - All buffers empty.
  - RR pointer = NUM_SRC-1, so source 0 wins first.
  - src_ready after reset = 1 for every source when freeze=0.
- Per-source 1-entry buffer holds {wen, rd, wdata}.
  - src_ready[i] = !freeze && (buffer i empty || buffer i granted this cycle).
  - On transfer, the buffer is loaded at the edge.
  - Same-cycle drain and refill is allowed: the grant takes the old entry and the buffer is reloaded with the new one.
- Arbitration (combinational, cycle N):
  - Candidates are the occupied buffers. No grant when freeze=1.
  - Search starts at pointer+1 mod NUM_SRC; first occupied buffer wins.
  - On grant, pointer ← winner at the edge. Pointer is unchanged when there is no grant.
- Output register, loaded at the edge ending cycle N:
  - On grant: wb_valid=1, wb_fu=winner, wb_rd=rd, s_wdata=wdata, wb_reg_en = wen && (rd != 0).
  - Without grant: wb_valid=0, wb_reg_en=0. wb_rd and s_wdata hold their previous value.
- Latency:
  - Completion accepted at edge E appears on wb_* during the cycle after edge E+1, i.e. 2 edges minimum.
  - Maximum additional wait is NUM_SRC-1 cycles with all sources busy and no freeze.
- Register x0: a completion with rd=0 still produces wb_valid=1 (FUST release) with wb_reg_en=0.
- Freeze:
  - No grants and no accepts; buffers and pointer hold.
  - wb_valid and wb_reg_en are 0 from the edge after freeze asserts.
  - Resume continues round-robin from the held pointer.
- Reset mid-operation: buffered completions are discarded, outputs cleared, pointer reset. Upstream FUs are reset by the same nRST.
- No completion is duplicated or lost outside reset. Each accepted entry produces exactly one wb_valid pulse.

Decomposition:
- datapath_pkg:
  - constants WB_SRC_ALU=0, WB_SRC_LDST=1, WB_SRC_BR=2.
  - wb_src_t struct {wen, rd, wdata}.
  - wb_fu field of the existing wb_t keyed to these constants.
- Sub-module rr_arbiter (parameter N):
  - inputs req[N], en, CLK, nRST.
  - outputs one-hot gnt and gnt_idx.
  - owns the pointer register; pointer updates only when en && |req.
- Top-level wb_arbiter holds the buffers, the ready logic and the output register.

Test Plan:
1. Single completion: ALU valid 1 cycle, wen=1, rd=5, wdata=0xDEADBEEF → src_ready[0]=1. After 2 edges: one pulse with wb_valid=1, wb_fu=0, wb_rd=5, wb_reg_en=1, s_wdata=0xDEADBEEF; wb_valid=0 next cycle.
2. Simultaneous: all three sources valid for 1 cycle (rd=1,2,3) from reset → wb_fu sequence 0,1,2 on three consecutive cycles, rd 1,2,3; then wb_valid=0.
3. Register x0: LDST completion with rd=0, wen=1 → wb_valid=1, wb_fu=1, wb_reg_en=0. Store with wen=0, rd=7 → wb_valid=1, wb_reg_en=0.
4. Fairness: ALU and LDST held valid continuously for 20 cycles → wb_fu alternates 0,1,0,1…; each source is accepted every other cycle via same-cycle refill; no source waits more than 1 cycle after its buffer fills.
5. Freeze: all buffers full, assert freeze for 3 cycles → src_ready=000 and wb_valid=0 for those cycles, buffers intact. After release, grants resume from the held pointer in order, 3 pulses total.
6. Reset mid-op: buffers full and wb_valid=1, nRST=0 for 1 edge → all outputs 0, buffers empty. Next ALU completion is granted first (pointer reset), with 2-edge latency.
